// File: rtl/wb_write_queue_if.sv
// wb_write_queue_if: MEM-stage result in, register-file write and decode hazard out
interface wb_write_queue_if;
  logic inValid;
  logic inWB_EN;
  logic inMEM_R_EN;
  logic [3:0] inDest;
  logic [31:0] aluResult;
  logic [31:0] memData;
  logic portBusy;
  logic [3:0] RnAddress;
  logic [3:0] RmAddress;
  logic Two_src;
  logic WB_EN;
  logic [3:0] WBDest;
  logic [31:0] WBValue;
  logic hazard;
  logic full;
  logic overflow;
  modport master (
    output inValid, inWB_EN, inMEM_R_EN, inDest, aluResult, memData,
    output portBusy, RnAddress, RmAddress, Two_src,
    input WB_EN, WBDest, WBValue, hazard, full, overflow
  );
  modport slave (
    input inValid, inWB_EN, inMEM_R_EN, inDest, aluResult, memData,
    input portBusy, RnAddress, RmAddress, Two_src,
    output WB_EN, WBDest, WBValue, hazard, full, overflow
  );
endinterface

// File: rtl/wb_write_queue.sv
// wb_write_queue: in-order write-back FIFO draining one register-file write per cycle
module wb_write_queue #(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  wb_write_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0] headPtr, tailPtr;
  logic [CW-1:0] count;
  logic [DEPTH-1:0] entryValid;
  logic [3:0] entryDest [DEPTH];
  logic [31:0] entryValue [DEPTH];
  logic overflowReg, isFull, notEmpty, push, pop, drop, hazardAny;
  assign notEmpty = count != '0;
  assign isFull = count == CW'(DEPTH);
  assign pop = notEmpty & ~q.portBusy;
  assign push = q.inValid & q.inWB_EN & (~isFull | pop);
  assign drop = q.inValid & q.inWB_EN & isFull & ~pop;
  // clear-then-set so a full-queue push+pop on the same slot keeps it valid
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      headPtr <= '0;
      tailPtr <= '0;
      count <= '0;
      entryValid <= '0;
      overflowReg <= 1'b0;
    end else begin
      if (pop) begin
        headPtr <= headPtr + 1'b1;
        entryValid[headPtr] <= 1'b0;
      end
      if (push) begin
        tailPtr <= tailPtr + 1'b1;
        entryValid[tailPtr] <= 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
      if (drop) overflowReg <= 1'b1;
    end
  always_ff @(posedge clk)
    if (push) begin
      entryDest[tailPtr] <= q.inDest;
      entryValue[tailPtr] <= q.inMEM_R_EN ? q.memData : q.aluResult;
    end
  // the entry being written this cycle still counts: its write lands at the edge
  always_comb begin
    hazardAny = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      hazardAny = hazardAny | (entryValid[i] & ((entryDest[i] == q.RnAddress) | (q.Two_src & (entryDest[i] == q.RmAddress))));
  end
  assign q.WB_EN = pop;
  assign q.WBDest = notEmpty ? entryDest[headPtr] : 4'd0;
  assign q.WBValue = notEmpty ? entryValue[headPtr] : 32'd0;
  assign q.hazard = hazardAny;
  assign q.full = isFull;
  assign q.overflow = overflowReg;
endmodule
